// File: rtl/store_write_buffer.sv
// Store write buffer between the MEM stage and a slow handshaked data memory.
// Stores drain from a FIFO in the background; loads forward from it on a hit.
// Define WBUF_COALESCE_EN to merge stores into a matching buffered entry.
module store_write_buffer #(
  parameter int DEPTH = 4,
  parameter int AW    = 32,
  parameter int DW    = 32
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic [AW-1:0] cpu_addr_i,
  input  logic [DW-1:0] cpu_wdata_i,
  input  logic          cpu_memwrite_i,
  input  logic          cpu_memread_i,
  output logic [DW-1:0] cpu_rdata_o,
  output logic          stall_o,
  output logic          mem_req_o,
  output logic          mem_we_o,
  output logic [AW-1:0] mem_addr_o,
  output logic [DW-1:0] mem_wdata_o,
  input  logic          mem_ack_i,
  input  logic [DW-1:0] mem_rdata_i,
  output logic          empty_o
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t state_q, state_d;

  logic [DEPTH-1:0] valid_q;
  logic [AW-3:0]    addr_q [DEPTH];
  logic [DW-1:0]    data_q [DEPTH];
  logic [PW-1:0]    head_q, tail_q;
  logic [PW:0]      count_q;
  logic [DW-1:0]    rdata_q;

  logic [AW-3:0] word_addr;
  logic          store_req, full, hit, load_miss, enq, coal, coal_hit, drain_ack;
  logic [DW-1:0] hit_data;
  logic [PW-1:0] fwd_idx, coal_idx;
  logic          unused_addr_bits;

  assign word_addr        = cpu_addr_i[AW-1:2];
  assign unused_addr_bits = ^cpu_addr_i[1:0];
  // A simultaneous load and store services the load and drops the store.
  assign store_req        = cpu_memwrite_i & ~cpu_memread_i;
  assign full             = (count_q == FULL_CNT);
  assign drain_ack        = (state_q == WRITE) & mem_ack_i;
  assign coal             = store_req & coal_hit;
  assign enq              = store_req & ~coal & ~full;
  assign load_miss        = cpu_memread_i & ~hit & (state_q != RESP);
  assign empty_o          = (count_q == '0);

  // Forwarding search: scanning oldest to youngest lets the youngest match win.
  always_comb begin
    hit      = 1'b0;
    hit_data = '0;
    fwd_idx  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      fwd_idx = head_q + PW'(i);
      if (valid_q[fwd_idx] && (addr_q[fwd_idx] == word_addr)) begin
        hit      = 1'b1;
        hit_data = data_q[fwd_idx];
      end else begin
        hit = hit;
      end
    end
  end

`ifdef WBUF_COALESCE_EN
  logic [PW-1:0] scan_idx;

  // Coalesce target: youngest match, except the head while it is being written.
  always_comb begin
    coal_hit = 1'b0;
    coal_idx = '0;
    scan_idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      scan_idx = head_q + PW'(i);
      if (valid_q[scan_idx] && (addr_q[scan_idx] == word_addr) &&
          !((scan_idx == head_q) && (state_q == WRITE))) begin
        coal_hit = 1'b1;
        coal_idx = scan_idx;
      end else begin
        coal_hit = coal_hit;
      end
    end
  end
`else
  assign coal_hit = 1'b0;
  assign coal_idx = '0;
`endif

  // Pipeline-facing load data and stall.
  always_comb begin
    stall_o     = 1'b0;
    cpu_rdata_o = rdata_q;
    if (cpu_memread_i) begin
      if (state_q == RESP) begin
        stall_o = 1'b0;
      end else if (hit) begin
        cpu_rdata_o = hit_data;
      end else begin
        stall_o = 1'b1;
      end
    end else if (store_req) begin
      stall_o = full & ~coal;
    end else begin
      stall_o = 1'b0;
    end
  end

  // Memory-side FSM next state and request outputs.
  always_comb begin
    state_d     = state_q;
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    case (state_q)
      IDLE: begin
        if (load_miss) begin
          state_d = READ;
        end else if (count_q != '0) begin
          state_d = WRITE;
        end else begin
          state_d = IDLE;
        end
      end
      WRITE: begin
        mem_req_o   = 1'b1;
        mem_we_o    = 1'b1;
        mem_addr_o  = {addr_q[head_q], 2'b00};
        mem_wdata_o = data_q[head_q];
        if (mem_ack_i) begin
          state_d = IDLE;
        end else begin
          state_d = WRITE;
        end
      end
      READ: begin
        mem_req_o  = 1'b1;
        mem_addr_o = {word_addr, 2'b00};
        if (mem_ack_i) begin
          state_d = RESP;
        end else begin
          state_d = READ;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Control state: FSM, pointers, occupancy, validity and the read-data latch.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      valid_q <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      if (enq) begin
        valid_q[tail_q] <= 1'b1;
        tail_q          <= tail_q + PW'(1);
      end
      if (drain_ack) begin
        valid_q[head_q] <= 1'b0;
        head_q          <= head_q + PW'(1);
      end
      count_q <= count_q + {{PW{1'b0}}, enq} - {{PW{1'b0}}, drain_ack};
      if ((state_q == READ) && mem_ack_i) begin
        rdata_q <= mem_rdata_i;
      end
    end
  end

  // Entry payload; only validity needs a reset value.
  always_ff @(posedge clk_i) begin
    if (enq) begin
      addr_q[tail_q] <= word_addr;
      data_q[tail_q] <= cpu_wdata_i;
    end
    if (coal) begin
      data_q[coal_idx] <= cpu_wdata_i;
    end
  end

endmodule

// File: tb/tb_store_write_buffer.sv
// Self-checking bench for store_write_buffer: directed vector table, hand-written
// corner sequences, and random traffic against a program-order memory model.
module tb_store_write_buffer;

  localparam int DEPTH = 4;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic [31:0] cpu_addr_i, cpu_wdata_i, cpu_rdata_o;
  logic        cpu_memwrite_i, cpu_memread_i, stall_o;
  logic        mem_req_o, mem_we_o, mem_ack_i, empty_o;
  logic [31:0] mem_addr_o, mem_wdata_o, mem_rdata_i;

  store_write_buffer #(.DEPTH(DEPTH), .AW(32), .DW(32)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .cpu_addr_i(cpu_addr_i), .cpu_wdata_i(cpu_wdata_i),
    .cpu_memwrite_i(cpu_memwrite_i), .cpu_memread_i(cpu_memread_i),
    .cpu_rdata_o(cpu_rdata_o), .stall_o(stall_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .mem_ack_i(mem_ack_i), .mem_rdata_i(mem_rdata_i),
    .empty_o(empty_o)
  );

  always #5 clk_i = ~clk_i;

  always @(posedge clk_i) begin
    if (!rst_i) begin
      assert (!(cpu_memread_i && cpu_memwrite_i))
        else $error("illegal simultaneous load and store");
    end
  end

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive_idle();
    cpu_memwrite_i = 1'b0;
    cpu_memread_i  = 1'b0;
    cpu_addr_i     = 32'h0;
    cpu_wdata_i    = 32'h0;
  endtask

  typedef struct {
    logic        we, re;
    logic [31:0] addr, wdata;
    logic        ack;
    logic [31:0] mrd;
    logic        stall, req, mwe;
    logic [31:0] maddr, mwdata, rdata;
    logic        empty;
  } vec_t;
  vec_t vecs[$];

  task automatic addv(input logic we, re, input logic [31:0] a, wd, input logic ack,
                      input logic [31:0] mrd, input logic st, rq, mwe,
                      input logic [31:0] ma, mwd, rd, input logic em);
    vec_t v;
    v.we = we; v.re = re; v.addr = a; v.wdata = wd; v.ack = ack; v.mrd = mrd;
    v.stall = st; v.req = rq; v.mwe = mwe; v.maddr = ma; v.mwdata = mwd;
    v.rdata = rd; v.empty = em;
    vecs.push_back(v);
  endtask

  task automatic expect_write(input string nm, input logic [31:0] a, input logic [31:0] d);
    int n = 0;
    mem_ack_i = 1'b0;
    while (!(mem_req_o === 1'b1 && mem_we_o === 1'b1) && n < 20) begin
      step();
      n++;
    end
    check({nm, "_seen"}, {31'd0, n < 20}, 32'd1);
    check({nm, "_addr"}, mem_addr_o, a);
    check({nm, "_data"}, mem_wdata_o, d);
    mem_ack_i = 1'b1;
    step();
    mem_ack_i = 1'b0;
  endtask

  // Reference model: architectural memory in program order, pending-store FIFO,
  // and the memory's own image updated only by acknowledged writes.
  typedef struct {
    logic [29:0] wa;
    logic [31:0] d;
  } ent_t;
  ent_t        wq[$];
  logic [31:0] arch_m [logic [29:0]];
  logic [31:0] mem_img [logic [29:0]];

  function automatic logic [31:0] init_val(input logic [29:0] wa);
    return {2'b00, wa} ^ 32'h5A5A_0000;
  endfunction

  function automatic logic [31:0] arch_rd(input logic [29:0] wa);
    if (arch_m.exists(wa)) return arch_m[wa];
    else return init_val(wa);
  endfunction

  function automatic logic [31:0] mem_rd(input logic [29:0] wa);
    if (mem_img.exists(wa)) return mem_img[wa];
    else return init_val(wa);
  endfunction

  function automatic bit in_wq(input logic [29:0] wa);
    for (int i = 0; i < wq.size(); i++) if (wq[i].wa == wa) return 1'b1;
    return 1'b0;
  endfunction

  function automatic int coal_target(input logic [29:0] wa, input bit wr_act);
    int j = -1;
`ifdef WBUF_COALESCE_EN
    for (int i = 0; i < wq.size(); i++)
      if (wq[i].wa == wa && !(i == 0 && wr_act)) j = i;
`endif
    return j;
  endfunction

  initial begin
    int          kind, age, lat, j;
    bit          busy, prev_req, prev_ack, prev_we, wr_act;
    logic [31:0] ra, rdv, prev_addr, prev_wdata;

    drive_idle();
    mem_ack_i   = 1'b0;
    mem_rdata_i = 32'h0;

    // Directed cycle table (inputs then expected outputs for that cycle).
    addv(0,0,32'h0,32'h0,0,32'h0,        0,0,0,32'h0,32'h0,32'h0,1);
    addv(1,0,32'h100,32'hA5A5A5A5,0,0,   0,0,0,32'h0,32'h0,32'h0,1);
    addv(0,0,32'h0,32'h0,0,32'h0,        0,0,0,32'h0,32'h0,32'h0,0);
    addv(0,0,32'h0,32'h0,0,32'h0,        0,1,1,32'h100,32'hA5A5A5A5,32'h0,0);
    addv(0,0,32'h0,32'h0,1,32'h0,        0,1,1,32'h100,32'hA5A5A5A5,32'h0,0);
    addv(0,0,32'h0,32'h0,0,32'h0,        0,0,0,32'h0,32'h0,32'h0,1);
    addv(0,1,32'h300,32'h0,0,32'h0,      1,0,0,32'h0,32'h0,32'h0,1);
    for (int k = 0; k < 3; k++)
      addv(0,1,32'h300,32'h0,0,32'h0,    1,1,0,32'h300,32'h0,32'h0,1);
    addv(0,1,32'h300,32'h0,1,32'hDEADBEEF, 1,1,0,32'h300,32'h0,32'h0,1);
    addv(0,1,32'h300,32'h0,0,32'h0,      0,0,0,32'h0,32'h0,32'hDEADBEEF,1);
    addv(0,0,32'h0,32'h0,0,32'h0,        0,0,0,32'h0,32'h0,32'h0,1);
    addv(1,0,32'h400,32'd1,0,32'h0,      0,0,0,32'h0,32'h0,32'h0,1);
    addv(1,0,32'h404,32'd2,0,32'h0,      0,0,0,32'h0,32'h0,32'h0,0);
    addv(1,0,32'h408,32'd3,0,32'h0,      0,1,1,32'h400,32'd1,32'h0,0);
    addv(1,0,32'h40C,32'd4,0,32'h0,      0,1,1,32'h400,32'd1,32'h0,0);
    addv(1,0,32'h410,32'd5,0,32'h0,      1,1,1,32'h400,32'd1,32'h0,0);
    addv(1,0,32'h410,32'd5,0,32'h0,      1,1,1,32'h400,32'd1,32'h0,0);
    addv(1,0,32'h410,32'd5,1,32'h0,      1,1,1,32'h400,32'd1,32'h0,0);
    addv(1,0,32'h410,32'd5,0,32'h0,      0,0,0,32'h0,32'h0,32'h0,0);
    addv(0,0,32'h0,32'h0,1,32'h0,        0,1,1,32'h404,32'd2,32'h0,0);
    addv(0,1,32'h40C,32'h0,0,32'h0,      0,0,0,32'h0,32'h0,32'd4,0);
    addv(0,1,32'h408,32'h0,1,32'h0,      0,1,1,32'h408,32'd3,32'd3,0);
    addv(0,0,32'h0,32'h0,0,32'h0,        0,0,0,32'h0,32'h0,32'h0,0);
    addv(0,0,32'h0,32'h0,1,32'h0,        0,1,1,32'h40C,32'd4,32'h0,0);
    addv(0,0,32'h0,32'h0,0,32'h0,        0,0,0,32'h0,32'h0,32'h0,0);
    addv(0,0,32'h0,32'h0,1,32'h0,        0,1,1,32'h410,32'd5,32'h0,0);
    addv(0,0,32'h0,32'h0,0,32'h0,        0,0,0,32'h0,32'h0,32'h0,1);

    // Reset values while reset is held.
    repeat (2) @(posedge clk_i);
    #1;
    check("rst_req", mem_req_o, 32'd0);
    check("rst_we", mem_we_o, 32'd0);
    check("rst_addr", mem_addr_o, 32'h0);
    check("rst_wdata", mem_wdata_o, 32'h0);
    check("rst_stall", stall_o, 32'd0);
    check("rst_rdata", cpu_rdata_o, 32'h0);
    check("rst_empty", empty_o, 32'd1);
    rst_i = 1'b0;

    for (int k = 0; k < vecs.size(); k++) begin
      cpu_memwrite_i = vecs[k].we;
      cpu_memread_i  = vecs[k].re;
      cpu_addr_i     = vecs[k].addr;
      cpu_wdata_i    = vecs[k].wdata;
      mem_ack_i      = vecs[k].ack;
      mem_rdata_i    = vecs[k].mrd;
      #1;
      check($sformatf("v%0d_stall", k), stall_o, vecs[k].stall);
      check($sformatf("v%0d_req", k), mem_req_o, vecs[k].req);
      check($sformatf("v%0d_empty", k), empty_o, vecs[k].empty);
      if (vecs[k].req) begin
        check($sformatf("v%0d_we", k), mem_we_o, vecs[k].mwe);
        check($sformatf("v%0d_maddr", k), mem_addr_o, vecs[k].maddr);
        if (vecs[k].mwe) check($sformatf("v%0d_mwdata", k), mem_wdata_o, vecs[k].mwdata);
      end
      if (vecs[k].re && !vecs[k].stall)
        check($sformatf("v%0d_rdata", k), cpu_rdata_o, vecs[k].rdata);
      step();
    end
    drive_idle();
    mem_ack_i = 1'b0;
    mem_rdata_i = 32'h0;

    // Two stores to one word, then a forwarded load while the drain is held off.
    cpu_memwrite_i = 1'b1; cpu_addr_i = 32'h200; cpu_wdata_i = 32'h11;
    step();
    cpu_wdata_i = 32'h22;
    step();
    cpu_memwrite_i = 1'b0; cpu_memread_i = 1'b1;
    #1;
    check("dup_ld_stall", stall_o, 32'd0);
    check("dup_ld_data", cpu_rdata_o, 32'h22);
    drive_idle();
`ifdef WBUF_COALESCE_EN
    expect_write("dup_w0", 32'h200, 32'h22);
`else
    expect_write("dup_w0", 32'h200, 32'h11);
    expect_write("dup_w1", 32'h200, 32'h22);
`endif
    step(); step();
    check("dup_empty", empty_o, 32'd1);
    check("dup_noreq", mem_req_o, 32'd0);

    // Load miss arriving while a write is outstanding.
    cpu_memwrite_i = 1'b1; cpu_addr_i = 32'h104; cpu_wdata_i = 32'h55;
    step();
    drive_idle();
    step();
    cpu_memread_i = 1'b1; cpu_addr_i = 32'h500;
    #1;
    check("lw_req", mem_req_o, 32'd1);
    check("lw_we", mem_we_o, 32'd1);
    check("lw_addr", mem_addr_o, 32'h104);
    check("lw_stall", stall_o, 32'd1);
    step();
    check("lw_still_write", mem_we_o, 32'd1);
    mem_ack_i = 1'b1;
    step();
    mem_ack_i = 1'b0;
    #1;
    check("lw_gap", mem_req_o, 32'd0);
    check("lw_gap_stall", stall_o, 32'd1);
    step();
    check("lw_rd_req", mem_req_o, 32'd1);
    check("lw_rd_we", mem_we_o, 32'd0);
    check("lw_rd_addr", mem_addr_o, 32'h500);
    mem_ack_i = 1'b1; mem_rdata_i = 32'h77;
    step();
    mem_ack_i = 1'b0;
    #1;
    check("lw_resp_stall", stall_o, 32'd0);
    check("lw_resp_data", cpu_rdata_o, 32'h77);
    check("lw_resp_req", mem_req_o, 32'd0);
    drive_idle();
    step();

    // Reset asserted mid-write with two entries buffered.
    cpu_memwrite_i = 1'b1; cpu_addr_i = 32'h600; cpu_wdata_i = 32'h61;
    step();
    cpu_addr_i = 32'h604; cpu_wdata_i = 32'h62;
    step();
    drive_idle();
    #1;
    check("mr_pre_req", mem_req_o, 32'd1);
    #1;
    rst_i = 1'b1;
    #1;
    check("mr_req", mem_req_o, 32'd0);
    check("mr_we", mem_we_o, 32'd0);
    check("mr_addr", mem_addr_o, 32'h0);
    check("mr_wdata", mem_wdata_o, 32'h0);
    check("mr_stall", stall_o, 32'd0);
    check("mr_rdata", cpu_rdata_o, 32'h0);
    check("mr_empty", empty_o, 32'd1);
    step(); step();
    rst_i = 1'b0;
    for (int k = 0; k < 8; k++) begin
      step();
      check("mr_quiet", mem_req_o, 32'd0);
    end
    check("mr_empty_after", empty_o, 32'd1);

    // Random traffic against the program-order model.
    busy = 1'b0; prev_req = 1'b0; prev_ack = 1'b0; prev_we = 1'b0;
    prev_addr = 32'h0; prev_wdata = 32'h0;
    kind = 0; age = 0; lat = 0; ra = 32'h0; rdv = 32'h0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (!busy) begin
        kind = (cyc < 2800) ? int'($urandom_range(0, 2)) : 0;
        ra   = 32'h800 + (32'($urandom_range(0, 7)) << 2) + 32'($urandom_range(0, 3));
        rdv  = $urandom;
        busy = (kind != 0);
        age  = 0;
      end
      cpu_memwrite_i = busy && (kind == 1);
      cpu_memread_i  = busy && (kind == 2);
      cpu_addr_i     = ra;
      cpu_wdata_i    = rdv;
      mem_ack_i      = 1'b0;
      mem_rdata_i    = 32'h0;
      #1;
      if (mem_req_o) begin
        if (lat == 0) begin
          mem_ack_i   = 1'b1;
          mem_rdata_i = mem_rd(mem_addr_o[31:2]);
          lat         = $urandom_range(0, 3);
        end else begin
          lat--;
        end
      end
      #1;
      if (prev_ack) begin
        check("r_gap", mem_req_o, 32'd0);
      end else if (prev_req) begin
        check("r_req_hold", mem_req_o, 32'd1);
        check("r_we_hold", mem_we_o, prev_we);
        check("r_addr_hold", mem_addr_o, prev_addr);
        if (prev_we) check("r_wdata_hold", mem_wdata_o, prev_wdata);
      end
      check("r_empty", empty_o, (wq.size() == 0) ? 32'd1 : 32'd0);
      wr_act = mem_req_o && mem_we_o;
      if (busy && kind == 1)
        check("r_st_stall", stall_o,
              (wq.size() == DEPTH && coal_target(ra[31:2], wr_act) < 0) ? 32'd1 : 32'd0);
      if (busy && kind == 2 && in_wq(ra[31:2])) check("r_hit_stall", stall_o, 32'd0);
      if (busy && kind == 2 && !stall_o) check("r_ld_data", cpu_rdata_o, arch_rd(ra[31:2]));
      if (mem_ack_i && mem_we_o) begin
        if (wq.size() == 0) begin
          check("r_spurious_write", 32'd1, 32'd0);
        end else begin
          check("r_wr_addr", mem_addr_o, {wq[0].wa, 2'b00});
          check("r_wr_data", mem_wdata_o, wq[0].d);
        end
      end
      if (mem_ack_i && !mem_we_o)
        check("r_rd_addr", mem_addr_o, (busy && kind == 2) ? {ra[31:2], 2'b00} : 32'hFFFF_FFFF);

      if (busy && !stall_o) begin
        if (kind == 1) begin
          arch_m[ra[31:2]] = rdv;
          j = coal_target(ra[31:2], wr_act);
          if (j >= 0) wq[j].d = rdv;
          else wq.push_back('{ra[31:2], rdv});
        end
        busy = 1'b0;
      end else if (busy) begin
        age++;
        if (age > 60) begin
          check("r_progress_cycles", 32'(age), 32'd0);
          busy = 1'b0;
        end
      end
      if (mem_ack_i && mem_we_o && wq.size() > 0) begin
        mem_img[mem_addr_o[31:2]] = mem_wdata_o;
        wq.pop_front();
      end
      prev_req   = mem_req_o;
      prev_ack   = mem_ack_i;
      prev_we    = mem_we_o;
      prev_addr  = mem_addr_o;
      prev_wdata = mem_wdata_o;
      step();
    end
    drive_idle();
    mem_ack_i = 1'b0;
    check("r_final_empty", empty_o, 32'd1);
    check("r_final_queue", 32'(wq.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
